dma_arbiter: RTL

Owns the single port of the `memory` block and shares it between the CPU and an OAM DMA engine. It also holds the two memory-configuration registers: DMA source (0xFF46) and boot-ROM disable (0xFF50). While DMA runs, the engine copies 160 bytes from `{src_hi,8'h00}` to 0xFE00–0xFE9F and locks the CPU off the bus. It sits between the CPU core and `memory`.

---
 rtl/gb_mem_pkg.sv | 23 ++
 rtl/dma_arbiter.sv | 111 +++++++++++
 2 files changed

// File: rtl/gb_mem_pkg.sv
// Shared memory-map constants and types for the Game Boy memory subsystem.
package gb_mem_pkg;

    localparam logic [15:0] DMA_REG      = 16'hFF46;
    localparam logic [15:0] BOOT_OFF_REG = 16'hFF50;
    localparam logic [15:0] OAM_BASE     = 16'hFE00;
    localparam int          OAM_LEN      = 160;

    typedef enum logic [1:0] {
        IDLE,
        START,
        READ,
        WRITE
    } dma_state_t;

    // Source of the registered CPU read data.
    typedef enum logic [1:0] {
        RD_MEM,
        RD_DMA,
        RD_BOOT
    } rd_sel_t;

endpackage

// File: rtl/dma_arbiter.sv
// Shares the memory port between the CPU and the OAM DMA engine, and holds
// the DMA source (0xFF46) and boot-ROM disable (0xFF50) registers.
module dma_arbiter
    import gb_mem_pkg::*;
#(
    parameter int          OAM_LEN  = gb_mem_pkg::OAM_LEN,
    parameter logic [15:0] OAM_BASE = gb_mem_pkg::OAM_BASE
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [15:0] cpu_addr,
    input  logic        cpu_wren,
    input  logic [7:0]  cpu_data_in,
    output logic [7:0]  cpu_data_out,
    output logic [15:0] mem_addr,
    output logic        mem_wren,
    output logic [7:0]  mem_data_in,
    input  logic [7:0]  mem_data_out,
    output logic        boot_rom_en,
    output logic        dma_active
);

    localparam logic [7:0] LAST_IDX = 8'(OAM_LEN - 1);

    dma_state_t state;
    rd_sel_t    rd_sel;
    logic [7:0] counter;
    logic [7:0] src_hi;
    logic       blocked_q;
    logic       reg_hit;
    logic       dma_wr;
    logic       boot_wr;

    assign dma_active = (state != IDLE);
    assign reg_hit    = (cpu_addr == DMA_REG) || (cpu_addr == BOOT_OFF_REG);
    // Register writes are only honoured while the CPU owns the bus.
    assign dma_wr     = (state == IDLE) && cpu_wren && (cpu_addr == DMA_REG);
    assign boot_wr    = (state == IDLE) && cpu_wren && (cpu_addr == BOOT_OFF_REG);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state       <= IDLE;
            counter     <= 8'h00;
            src_hi      <= 8'h00;
            boot_rom_en <= 1'b1;
            blocked_q   <= 1'b0;
            rd_sel      <= RD_MEM;
        end else begin
            blocked_q <= dma_active;
            if (cpu_addr == DMA_REG)
                rd_sel <= RD_DMA;
            else if (cpu_addr == BOOT_OFF_REG)
                rd_sel <= RD_BOOT;
            else
                rd_sel <= RD_MEM;

            if (boot_wr && (cpu_data_in != 8'h00))
                boot_rom_en <= 1'b0;

            case (state)
                IDLE: begin
                    if (dma_wr) begin
                        src_hi  <= cpu_data_in;
                        counter <= 8'h00;
                        state   <= START;
                    end
                end
                START: state <= READ;
                READ:  state <= WRITE;
                WRITE: begin
                    if (counter == LAST_IDX) begin
                        counter <= 8'h00;
                        state   <= IDLE;
                    end else begin
                        counter <= counter + 8'h01;
                        state   <= READ;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // WRITE forwards the byte the memory returns for the preceding READ.
    always_comb begin
        mem_addr    = cpu_addr;
        mem_wren    = 1'b0;
        mem_data_in = cpu_data_in;
        case (state)
            IDLE:  mem_wren = cpu_wren && !reg_hit;
            READ:  mem_addr = {src_hi, counter};
            WRITE: begin
                mem_addr    = OAM_BASE + {8'h00, counter};
                mem_wren    = 1'b1;
                mem_data_in = mem_data_out;
            end
            default: ;
        endcase
    end

    always_comb begin
        cpu_data_out = mem_data_out;
        if (blocked_q)
            cpu_data_out = 8'hFF;
        else if (rd_sel == RD_DMA)
            cpu_data_out = src_hi;
        else if (rd_sel == RD_BOOT)
            cpu_data_out = {7'h7F, ~boot_rom_en};
    end

endmodule
